// File: rtl/output_argmax.sv
// ---------------------------------------------------------------------------
// output_argmax
//
// Sequential classifier stage downstream of the neural network core. The
// block captures the final-layer score vector on a scores_ready pulse, scans
// it one element per clock to find the highest score, and presents the
// winning class through a valid/accept handshake.
//
// Ports:
//   clock         in   rising-edge clock
//   reset         in   asynchronous, active-high reset
//   scores_ready  in   one-cycle pulse, scores valid in this cycle
//   scores        in   NUM_CLASSES x W signed fixed-point scores
//   class_index   out  index of the maximum score (lowest index on ties)
//   class_score   out  maximum score, bit pattern identical to the input
//   class_valid   out  result available, held until accepted
//   class_accept  in   consumer takes the result on an edge with class_valid=1
//   busy          out  high while scanning or holding a result
//   drop_count    out  saturating count of ignored scores_ready pulses
//
// Handshake: a result is transferred on every rising edge where
// class_valid=1 and class_accept=1. While class_valid=1 the outputs
// class_index/class_score do not change. class_accept while class_valid=0
// has no effect. A new vector may be captured on the same edge that the
// previous result is accepted.
// ---------------------------------------------------------------------------

package fixed_point_pkg;
    localparam int INTEGER_WIDTH  = 8;
    localparam int FRACTION_WIDTH = 8;
endpackage

module output_argmax
    import fixed_point_pkg::*;
#(
    parameter  int NUM_CLASSES      = 10,
    parameter  int DROP_COUNT_WIDTH = 8,
    localparam int IDX_W            = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
    localparam int W                = INTEGER_WIDTH + FRACTION_WIDTH
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        scores_ready,
    // Fixed-point format: bit W-1 is integer bit INTEGER_WIDTH-1, bit 0 is
    // fraction bit -FRACTION_WIDTH.
    input  logic signed [W-1:0]         scores [NUM_CLASSES],
    output logic [IDX_W-1:0]            class_index,
    output logic signed [W-1:0]         class_score,
    output logic                        class_valid,
    input  logic                        class_accept,
    output logic                        busy,
    output logic [DROP_COUNT_WIDTH-1:0] drop_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    state_t              state;
    logic signed [W-1:0] scores_q [NUM_CLASSES];
    logic signed [W-1:0] best;
    logic [IDX_W-1:0]    best_idx;
    logic [IDX_W-1:0]    scan_idx;

    logic                capture;
    logic                drop;
    logic signed [W-1:0] cand;
    logic                take;

    always_comb begin
        // A vector is taken when idle, or in HOLD on the same edge the
        // pending result is accepted (back-to-back operation).
        capture = scores_ready && ((state == IDLE) || ((state == HOLD) && class_accept));
        drop    = scores_ready && !capture;
        cand    = scores_q[scan_idx];
        // Strict compare so equal scores keep the lower index.
        take    = (cand > best);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            for (int k = 0; k < NUM_CLASSES; k++) begin
                scores_q[k] <= '0;
            end
            best        <= '0;
            best_idx    <= '0;
            scan_idx    <= '0;
            class_index <= '0;
            class_score <= '0;
            class_valid <= 1'b0;
            busy        <= 1'b0;
            drop_count  <= '0;
        end else begin
            if (drop && (drop_count != {DROP_COUNT_WIDTH{1'b1}})) begin
                drop_count <= drop_count + DROP_COUNT_WIDTH'(1);
            end

            if (capture) begin
                scores_q <= scores;
                best     <= scores[0];
                best_idx <= '0;
                scan_idx <= IDX_W'(1);
                busy     <= 1'b1;
                if (NUM_CLASSES == 1) begin
                    // Nothing to scan: the single score is the result.
                    class_index <= '0;
                    class_score <= scores[0];
                    class_valid <= 1'b1;
                    state       <= HOLD;
                end else begin
                    class_valid <= 1'b0;
                    state       <= SCAN;
                end
            end else begin
                case (state)
                    SCAN: begin
                        if (scan_idx == LAST_IDX) begin
                            // The final comparison feeds the outputs directly
                            // so the last element is included in the result.
                            class_index <= take ? scan_idx : best_idx;
                            class_score <= take ? cand : best;
                            class_valid <= 1'b1;
                            state       <= HOLD;
                        end else begin
                            if (take) begin
                                best     <= cand;
                                best_idx <= scan_idx;
                            end
                            scan_idx <= scan_idx + IDX_W'(1);
                        end
                    end
                    HOLD: begin
                        if (class_accept) begin
                            class_valid <= 1'b0;
                            busy        <= 1'b0;
                            state       <= IDLE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_output_argmax.sv
// ---------------------------------------------------------------------------
// tb_output_argmax
//
// Bench for output_argmax. dut drives the default configuration
// (NUM_CLASSES=10, DROP_COUNT_WIDTH=8); dut_one uses NUM_CLASSES=1 with a
// 2-bit drop counter to cover the direct-to-HOLD path and counter saturation.
// Expected results are computed from each captured vector by a reference
// argmax and queued in exp_q; they are compared when the result is accepted.
// ---------------------------------------------------------------------------

module tb_output_argmax;
    import fixed_point_pkg::*;

    localparam int NUM   = 10;
    localparam int W     = INTEGER_WIDTH + FRACTION_WIDTH;
    localparam int IDX_W = (NUM > 1) ? $clog2(NUM) : 1;
    localparam int LATENCY = NUM - 1;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // ---------------- main DUT signals ----------------
    logic                scores_ready;
    logic signed [W-1:0] scores [NUM];
    logic [IDX_W-1:0]    class_index;
    logic [W-1:0]        class_score;
    logic                class_valid;
    logic                class_accept;
    logic                busy;
    logic [7:0]          drop_count;

    // ---------------- single-class DUT signals ----------------
    logic                scores_ready1;
    logic signed [W-1:0] scores1 [1];
    logic [0:0]          class_index1;
    logic [W-1:0]        class_score1;
    logic                class_valid1;
    logic                class_accept1;
    logic                busy1;
    logic [1:0]          drop_count1;

    output_argmax #(.NUM_CLASSES(NUM), .DROP_COUNT_WIDTH(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .scores_ready (scores_ready),
        .scores       (scores),
        .class_index  (class_index),
        .class_score  (class_score),
        .class_valid  (class_valid),
        .class_accept (class_accept),
        .busy         (busy),
        .drop_count   (drop_count)
    );

    output_argmax #(.NUM_CLASSES(1), .DROP_COUNT_WIDTH(2)) dut_one (
        .clock        (clock),
        .reset        (reset),
        .scores_ready (scores_ready1),
        .scores       (scores1),
        .class_index  (class_index1),
        .class_score  (class_score1),
        .class_valid  (class_valid1),
        .class_accept (class_accept1),
        .busy         (busy1),
        .drop_count   (drop_count1)
    );

    // ---------------- scoreboard ----------------
    logic [IDX_W+W-1:0]  exp_q [$];
    logic signed [W-1:0] vec [NUM];
    int                  checks = 0;
    int                  errors = 0;
    int                  exp_drop = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: find the maximum value, then the first index holding it.
    function automatic logic [IDX_W+W-1:0] argmax_ref(input logic signed [W-1:0] v [NUM]);
        int mx;
        logic [IDX_W-1:0] ix;
        mx = v[0];
        foreach (v[k]) if (int'(v[k]) > mx) mx = v[k];
        ix = '0;
        for (int k = NUM - 1; k >= 0; k--) begin
            if (int'(v[k]) == mx) ix = IDX_W'(k);
        end
        return {ix, v[ix]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic scramble_scores();
        foreach (scores[k]) scores[k] = W'($urandom);
    endtask

    // Present vec with scores_ready for one edge; DUT must be able to take it.
    task automatic capture_vec();
        scores = vec;
        scores_ready = 1'b1;
        exp_q.push_back(argmax_ref(vec));
        step();
        scores_ready = 1'b0;
        scramble_scores();
    endtask

    // scores_ready pulse that the DUT is expected to ignore.
    task automatic pulse_drop();
        scramble_scores();
        scores_ready = 1'b1;
        step();
        scores_ready = 1'b0;
        exp_drop++;
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!class_valid && cycles < 40) begin
            step();
            cycles++;
        end
        if (!class_valid) check("valid_timeout", 32'(class_valid), 32'd1);
    endtask

    task automatic check_result(input string tag);
        logic [IDX_W+W-1:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_exp_q_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_valid"}, 32'(class_valid), 32'd1);
            check({tag, "_index"}, 32'(class_index), 32'(e[IDX_W+W-1:W]));
            check({tag, "_score"}, 32'(class_score), 32'(e[W-1:0]));
        end
    endtask

    task automatic accept_result(input string tag);
        check_result(tag);
        class_accept = 1'b1;
        step();
        class_accept = 1'b0;
        check({tag, "_valid_clr"}, 32'(class_valid), 32'd0);
        check({tag, "_busy_clr"}, 32'(busy), 32'd0);
    endtask

    task automatic random_vec();
        int mode;
        mode = $urandom_range(0, 2);
        foreach (vec[k]) begin
            case (mode)
                0:       vec[k] = W'($urandom);
                1:       vec[k] = W'($signed($urandom_range(0, 6)) - 3);
                default: vec[k] = 16'sh0040;
            endcase
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int cyc;
        int seen;
        logic [W-1:0] s1;

        reset = 1'b1;
        scores_ready = 1'b0;
        class_accept = 1'b0;
        scores_ready1 = 1'b0;
        class_accept1 = 1'b0;
        scores1[0] = '0;
        scramble_scores();
        repeat (3) step();

        check("rst_index", 32'(class_index), 32'd0);
        check("rst_score", 32'(class_score), 32'd0);
        check("rst_valid", 32'(class_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);
        check("rst_one_valid", 32'(class_valid1), 32'd0);
        #3 reset = 1'b0;
        step();

        // Accept with nothing pending is ignored.
        class_accept = 1'b1;
        step();
        class_accept = 1'b0;
        check("idle_accept_valid", 32'(class_valid), 32'd0);
        check("idle_accept_busy", 32'(busy), 32'd0);

        // Overrun: 3 pulses during SCAN, 2 in HOLD.
        random_vec();
        capture_vec();
        repeat (3) begin
            pulse_drop();
            step();
        end
        wait_valid(cyc);
        repeat (2) pulse_drop();
        check("overrun_drop", 32'(drop_count), 32'd5);
        accept_result("overrun");

        // Basic argmax with latency check.
        foreach (vec[k]) vec[k] = W'(k * 26);
        vec[7] = 16'sh0300;
        capture_vec();
        check("basic_busy", 32'(busy), 32'd1);
        wait_valid(cyc);
        check("basic_latency", 32'(cyc), 32'(LATENCY));
        check("basic_index", 32'(class_index), 32'd7);
        check("basic_score", 32'(class_score), 32'h0300);
        accept_result("basic");

        // Ties and negatives.
        foreach (vec[k]) vec[k] = 16'shFF00;
        vec[2] = 16'shFFC0;
        vec[5] = 16'shFFC0;
        capture_vec();
        wait_valid(cyc);
        check("tie_index", 32'(class_index), 32'd2);
        check("tie_score", 32'(class_score), 32'h0000FFC0);
        accept_result("tie");

        // Maximum at index 0, then only at the last index.
        foreach (vec[k]) vec[k] = W'($urandom_range(0, 16'h7FFE));
        vec[0] = 16'sh7FFF;
        capture_vec();
        wait_valid(cyc);
        check("max0_index", 32'(class_index), 32'd0);
        accept_result("max0");

        foreach (vec[k]) vec[k] = 16'sh7FFE;
        vec[NUM-1] = 16'sh7FFF;
        capture_vec();
        wait_valid(cyc);
        check("max9_index", 32'(class_index), 32'(NUM - 1));

        // Hold stability for 5 cycles, then back-to-back accept + capture.
        repeat (5) begin
            step();
            check("hold_valid", 32'(class_valid), 32'd1);
            check("hold_index", 32'(class_index), 32'(NUM - 1));
            check("hold_score", 32'(class_score), 32'h7FFF);
        end
        check_result("b2b_first");
        foreach (vec[k]) vec[k] = W'($urandom_range(0, 16'h0FFF));
        vec[4] = 16'sh1000;
        scores = vec;
        scores_ready = 1'b1;
        class_accept = 1'b1;
        exp_q.push_back(argmax_ref(vec));
        step();
        scores_ready = 1'b0;
        class_accept = 1'b0;
        scramble_scores();
        check("b2b_valid_clr", 32'(class_valid), 32'd0);
        check("b2b_busy", 32'(busy), 32'd1);
        wait_valid(cyc);
        check("b2b_latency", 32'(cyc), 32'(LATENCY));
        check("b2b_index", 32'(class_index), 32'd4);
        check("b2b_drop", 32'(drop_count), 32'(exp_drop));
        accept_result("b2b_second");

        // Randomized vectors, occasional drops and accept delays.
        for (int n = 0; n < 40; n++) begin
            random_vec();
            capture_vec();
            if ($urandom_range(0, 1) == 1) pulse_drop();
            wait_valid(cyc);
            repeat ($urandom_range(0, 3)) step();
            accept_result("rand");
        end
        check("rand_drop", 32'(drop_count), 32'(exp_drop));

        // Single-class instance: result straight after capture, saturation.
        s1 = W'($urandom);
        scores1[0] = s1;
        scores_ready1 = 1'b1;
        step();
        scores_ready1 = 1'b0;
        scores1[0] = ~s1;
        check("one_valid", 32'(class_valid1), 32'd1);
        check("one_index", 32'(class_index1), 32'd0);
        check("one_score", 32'(class_score1), 32'(s1));
        repeat (6) begin
            scores_ready1 = 1'b1;
            step();
            scores_ready1 = 1'b0;
        end
        check("one_drop_sat", 32'(drop_count1), 32'd3);
        check("one_score_kept", 32'(class_score1), 32'(s1));
        class_accept1 = 1'b1;
        step();
        class_accept1 = 1'b0;
        check("one_valid_clr", 32'(class_valid1), 32'd0);
        check("one_busy_clr", 32'(busy1), 32'd0);

        // Asynchronous reset in the middle of a scan.
        random_vec();
        capture_vec();
        void'(exp_q.pop_back());
        repeat (3) step();
        #2 reset = 1'b1;
        #1;
        check("abort_valid", 32'(class_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_index", 32'(class_index), 32'd0);
        check("abort_score", 32'(class_score), 32'd0);
        check("abort_drop", 32'(drop_count), 32'd0);
        exp_drop = 0;
        step();
        #3 reset = 1'b0;
        seen = 0;
        repeat (15) begin
            step();
            if (class_valid) seen++;
        end
        check("abort_no_valid", 32'(seen), 32'd0);

        foreach (vec[k]) vec[k] = W'($urandom);
        capture_vec();
        wait_valid(cyc);
        check("post_abort_latency", 32'(cyc), 32'(LATENCY));
        accept_result("post_abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
